r2_lut_addr_gen: RTL and testbench

Streaming address generator placed directly upstream of the force-coefficient lookup tables (c0/c1 tables, 3072 × 32-bit, 2-cycle registered single-port read). It accepts one float32 r² per cycle and decodes the exponent into a segment index and the top mantissa bits into a bin index, forming the shared table address. It flags r² values outside the tabulated range. It delays the interpolation fraction and status through a sideband pipe so they leave aligned with the table's `q`.

---
 rtl/r2_lut_pkg.sv | 24 ++
 rtl/r2_lut_addr_gen_if.sv | 26 ++
 rtl/sideband_delay.sv | 30 +++
 rtl/r2_lut_addr_gen.sv | 108 ++++++++++
 tb/tb_r2_lut_addr_gen.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/r2_lut_pkg.sv
// Shared constants for the r2 lookup-table address generator: table geometry,
// float32 field positions and the out-of-range counter width.
package r2_lut_pkg;

    localparam int SEGMENT_NUM = 12;
    localparam int BIN_WIDTH   = 8;
    localparam int MIN_EXP     = 115;
    localparam int ADDR_WIDTH  = 12;
    localparam int LUT_LATENCY = 2;

    localparam int SIGN_BIT    = 31;
    localparam int EXP_MSB     = 30;
    localparam int EXP_LSB     = 23;
    localparam int MANT_MSB    = 22;
    localparam int MANT_WIDTH  = 23;

    localparam int CNT_WIDTH   = 16;

    // Saturating increment: a pinned counter means "at least this many".
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/r2_lut_addr_gen_if.sv
// r2 stream in, table address/enable and aligned sideband out. The master
// modport is the r2 producer side; the slave modport is the address generator.
interface r2_lut_addr_gen_if #(
    parameter int ADDR_WIDTH = r2_lut_pkg::ADDR_WIDTH,
    parameter int FRAC_WIDTH = r2_lut_pkg::MANT_WIDTH - r2_lut_pkg::BIN_WIDTH
);
    logic                  r2_valid;
    logic [31:0]           r2;
    logic [ADDR_WIDTH-1:0] lut_addr;
    logic                  lut_rden;
    logic                  out_valid;
    logic                  out_in_range;
    logic                  out_near;
    logic [FRAC_WIDTH-1:0] out_frac;
    logic [31:0]           out_r2;

    modport master (
        output r2_valid, r2,
        input  lut_addr, lut_rden, out_valid, out_in_range, out_near, out_frac, out_r2
    );

    modport slave (
        input  r2_valid, r2,
        output lut_addr, lut_rden, out_valid, out_in_range, out_near, out_frac, out_r2
    );
endinterface

// File: rtl/sideband_delay.sv
// Fixed-depth register shift line with asynchronous reset; carries the packed
// sideband bus alongside the coefficient-table read latency.
module sideband_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stage;

    // NOTE: this is a flop line rather than a RAM, so every stage is reset;
    // otherwise stale valid bits would emerge after a mid-stream reset.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            stage <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/r2_lut_addr_gen.sv
// Decodes float32 r2 into a segment/bin table address and delays the fraction
// and status to line up with table q. Optional macro: R2_OOR_COUNT_EN.
module r2_lut_addr_gen #(
    parameter int SEGMENT_NUM = r2_lut_pkg::SEGMENT_NUM,
    parameter int BIN_WIDTH   = r2_lut_pkg::BIN_WIDTH,
    parameter int MIN_EXP     = r2_lut_pkg::MIN_EXP,
    parameter int ADDR_WIDTH  = r2_lut_pkg::ADDR_WIDTH,
    parameter int LUT_LATENCY = r2_lut_pkg::LUT_LATENCY
) (
    input  logic                clock,
    input  logic                rst,
    r2_lut_addr_gen_if.slave    bus
`ifdef R2_OOR_COUNT_EN
    ,
    output logic [r2_lut_pkg::CNT_WIDTH-1:0] oor_near_cnt,
    output logic [r2_lut_pkg::CNT_WIDTH-1:0] oor_far_cnt
`endif
);

    import r2_lut_pkg::*;

    localparam int FRAC_WIDTH = MANT_WIDTH - BIN_WIDTH;
    localparam int SEG_WIDTH  = ADDR_WIDTH - BIN_WIDTH;
    localparam int SB_WIDTH   = 3 + FRAC_WIDTH + 32;
    localparam logic [8:0] EXP_LO = 9'(MIN_EXP);
    localparam logic [8:0] EXP_HI = 9'(MIN_EXP + SEGMENT_NUM);

    logic                  sign;
    logic [7:0]            exp_f;
    logic [MANT_WIDTH-1:0] mant;
    logic [7:0]            seg_full;
    logic                  near;
    logic                  far;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [FRAC_WIDTH-1:0] frac_d;

    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave a value unassigned and infer a latch.
    always_comb begin
        addr_d   = '0;
        frac_d   = '0;
        sign     = bus.r2[SIGN_BIT];
        exp_f    = bus.r2[EXP_MSB:EXP_LSB];
        mant     = bus.r2[MANT_MSB:0];
        near     = ({1'b0, exp_f} < EXP_LO) || (bus.r2[SIGN_BIT-1:0] == '0);
        far      = ({1'b0, exp_f} >= EXP_HI) || sign;
        in_range = !near && !far;
        seg_full = exp_f - 8'(MIN_EXP);
        if (in_range) begin
            // Segment index above, mantissa bin below: the multiply by 2^BIN_WIDTH is free.
            addr_d = {seg_full[SEG_WIDTH-1:0], mant[MANT_MSB -: BIN_WIDTH]};
            frac_d = mant[FRAC_WIDTH-1:0];
        end
    end

    logic [ADDR_WIDTH-1:0] lut_addr_q;
    logic                  lut_rden_q;
    logic [SB_WIDTH-1:0]   sb_q;
    logic [SB_WIDTH-1:0]   sb_out;

    // NOTE: state registers use non-blocking assignments so all flops sample
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            lut_addr_q <= '0;
            lut_rden_q <= 1'b0;
            sb_q       <= '0;
        end else begin
            lut_rden_q <= bus.r2_valid && in_range;
            if (bus.r2_valid) begin
                lut_addr_q <= addr_d;
            end
            sb_q <= {bus.r2_valid, in_range, near, frac_d, bus.r2};
        end
    end

    sideband_delay #(
        .WIDTH (SB_WIDTH),
        .DEPTH (LUT_LATENCY)
    ) u_sideband_delay (
        .clock (clock),
        .rst   (rst),
        .din   (sb_q),
        .dout  (sb_out)
    );

    assign bus.lut_addr = lut_addr_q;
    assign bus.lut_rden = lut_rden_q;
    assign {bus.out_valid, bus.out_in_range, bus.out_near, bus.out_frac, bus.out_r2} = sb_out;

`ifdef R2_OOR_COUNT_EN
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            oor_near_cnt <= '0;
            oor_far_cnt  <= '0;
        end else begin
            if (bus.r2_valid && near) begin
                oor_near_cnt <= sat_inc(oor_near_cnt);
            end
            if (bus.r2_valid && far) begin
                oor_far_cnt <= sat_inc(oor_far_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_r2_lut_addr_gen.sv
// Self-checking bench for r2_lut_addr_gen: directed table points, a full
// address sweep, randomized traffic against a reference model, and resets.
module tb_r2_lut_addr_gen;

    logic clock = 1'b0;
    logic rst;
    always #5 clock = ~clock;

    r2_lut_addr_gen_if bus ();

`ifdef R2_OOR_COUNT_EN
    logic [15:0] oor_near_cnt;
    logic [15:0] oor_far_cnt;
`endif

    r2_lut_addr_gen dut (
        .clock        (clock),
        .rst          (rst),
        .bus          (bus)
`ifdef R2_OOR_COUNT_EN
        ,
        .oor_near_cnt (oor_near_cnt),
        .oor_far_cnt  (oor_far_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          v;
        logic [31:0] r2;
    } ent_t;

    ent_t        hist [3];
    logic [11:0] exp_addr;
    bit          exp_rden;
    bit          exp_ovalid;
    bit          exp_inr;
    bit          exp_near;
    logic [14:0] exp_frac;
    logic [31:0] exp_r2;
    int          exp_near_cnt;
    int          exp_far_cnt;

    logic [31:0] dir_r2   [8] = '{32'h3F000000, 32'h3BFFFFFF, 32'h3E800000, 32'h3F800000,
                                  32'hBF000000, 32'h7FC00000, 32'h39000000, 32'h00000000};
    int          dir_addr [8] = '{2816, 1279, 2560, 0, 0, 0, 0, 0};
    bit          dir_inr  [8] = '{1, 1, 1, 0, 0, 0, 0, 0};
    bit          dir_near [8] = '{0, 0, 0, 0, 0, 0, 1, 1};
    int          dir_frac [8] = '{0, 32767, 0, 0, 0, 0, 0, 0};

    logic [31:0] sweep_in [3072];

    // Reference classification from the float32 encoding, done with integer arithmetic.
    function automatic void model(input logic [31:0] x, output bit inr, output bit nr,
                                  output bit fr, output int addr, output int frac);
        int e;
        int m;
        e    = int'(x[30:23]);
        m    = int'(x[22:0]);
        nr   = (e < 115) || (x[30:0] == 31'd0);
        fr   = (e >= 115 + 12) || (x[31] == 1'b1);
        inr  = !nr && !fr;
        addr = inr ? (e - 115) * 256 + m / 32768 : 0;
        frac = inr ? m % 32768 : 0;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 3; i++) begin
            hist[i].v  = 1'b0;
            hist[i].r2 = '0;
        end
        exp_addr     = '0;
        exp_rden     = 1'b0;
        exp_ovalid   = 1'b0;
        exp_near_cnt = 0;
        exp_far_cnt  = 0;
    endtask

    // Applies one input for one clock and advances the model; outputs are sampled 1 unit after the edge.
    task automatic drive(input bit v, input logic [31:0] d);
        bit inr, nr, fr;
        int a, f;
        bus.r2_valid = v;
        bus.r2       = d;
        @(posedge clock);
        #1;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0].v  = v;
        hist[0].r2 = d;
        model(d, inr, nr, fr, a, f);
        exp_rden = v && inr;
        if (v) exp_addr = 12'(a);
        if (v && nr && exp_near_cnt < 65535) exp_near_cnt++;
        if (v && fr && exp_far_cnt < 65535) exp_far_cnt++;
        model(hist[2].r2, inr, nr, fr, a, f);
        exp_ovalid = hist[2].v;
        exp_inr    = inr;
        exp_near   = nr;
        exp_frac   = 15'(f);
        exp_r2     = hist[2].r2;
    endtask

    task automatic test_reset();
        bus.r2_valid = 1'b0;
        bus.r2       = '0;
        rst          = 1'b1;
        #12;
        n_tests++; if (bus.lut_addr !== 12'd0) begin n_fail++; $display("FAIL reset_lut_addr: got %0h expected 0", bus.lut_addr); end
        n_tests++; if (bus.lut_rden !== 1'b0) begin n_fail++; $display("FAIL reset_lut_rden: got %b expected 0", bus.lut_rden); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_tests++; if (bus.out_in_range !== 1'b0 || bus.out_near !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got in_range=%b near=%b expected 0 0", bus.out_in_range, bus.out_near); end
        n_tests++; if (bus.out_frac !== 15'd0 || bus.out_r2 !== 32'd0) begin n_fail++; $display("FAIL reset_data: got frac=%0h r2=%0h expected 0 0", bus.out_frac, bus.out_r2); end
`ifdef R2_OOR_COUNT_EN
        n_tests++; if (oor_near_cnt !== 16'd0 || oor_far_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_counters: got %0d %0d expected 0 0", oor_near_cnt, oor_far_cnt); end
`endif
        @(posedge clock);
        #1;
        rst = 1'b0;
        clear_model();
    endtask

    task automatic test_directed();
        int j;
        for (int k = 0; k < 10; k++) begin
            drive(k < 8, (k < 8) ? dir_r2[k] : 32'd0);
            if (k < 8) begin
                n_tests++; if (bus.lut_addr !== 12'(dir_addr[k])) begin n_fail++; $display("FAIL directed_addr[%0d]: got %0d expected %0d", k, bus.lut_addr, dir_addr[k]); end
                n_tests++; if (bus.lut_rden !== dir_inr[k]) begin n_fail++; $display("FAIL directed_rden[%0d]: got %b expected %b", k, bus.lut_rden, dir_inr[k]); end
            end else begin
                n_tests++; if (bus.lut_rden !== 1'b0 || bus.lut_addr !== 12'd0) begin n_fail++; $display("FAIL directed_idle[%0d]: got rden=%b addr=%0d expected 0 0", k, bus.lut_rden, bus.lut_addr); end
            end
            if (k >= 2) begin
                j = k - 2;
                n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL directed_out_valid[%0d]: got %b expected 1", j, bus.out_valid); end
                n_tests++; if (bus.out_in_range !== dir_inr[j]) begin n_fail++; $display("FAIL directed_in_range[%0d]: got %b expected %b", j, bus.out_in_range, dir_inr[j]); end
                n_tests++; if (bus.out_near !== dir_near[j]) begin n_fail++; $display("FAIL directed_near[%0d]: got %b expected %b", j, bus.out_near, dir_near[j]); end
                n_tests++; if (bus.out_frac !== 15'(dir_frac[j])) begin n_fail++; $display("FAIL directed_frac[%0d]: got %0h expected %0h", j, bus.out_frac, dir_frac[j]); end
                n_tests++; if (bus.out_r2 !== dir_r2[j]) begin n_fail++; $display("FAIL directed_r2[%0d]: got %0h expected %0h", j, bus.out_r2, dir_r2[j]); end
            end
        end
        drive(1'b0, 32'd0);
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL directed_drain: got out_valid=%b expected 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        for (int i = 0; i < 3074; i++) begin
            if (i < 3072) begin
                d = {1'b0, 8'(115 + i / 256), 8'(i % 256), 15'($urandom)};
                sweep_in[i] = d;
                drive(1'b1, d);
                n_tests++; if (bus.lut_addr !== 12'(i) || bus.lut_rden !== 1'b1) begin n_fail++; $display("FAIL sweep_addr[%0d]: got addr=%0d rden=%b expected %0d 1", i, bus.lut_addr, bus.lut_rden, i); end
            end else begin
                drive(1'b0, 32'd0);
            end
            if (i >= 2) begin
                n_tests++; if (bus.out_valid !== 1'b1 || bus.out_in_range !== 1'b1) begin n_fail++; $display("FAIL sweep_valid[%0d]: got valid=%b in_range=%b expected 1 1", i - 2, bus.out_valid, bus.out_in_range); end
                n_tests++; if (bus.out_r2 !== sweep_in[i-2] || bus.out_frac !== sweep_in[i-2][14:0]) begin n_fail++; $display("FAIL sweep_r2[%0d]: got r2=%0h frac=%0h expected %0h %0h", i - 2, bus.out_r2, bus.out_frac, sweep_in[i-2], sweep_in[i-2][14:0]); end
            end
        end
        drive(1'b0, 32'd0);
    endtask

    task automatic test_random();
        bit          v;
        logic [31:0] d;
        int          sel;
        for (int i = 0; i < 600; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 15);
            case (sel)
                0:       d = 32'h00000000;
                1:       d = 32'h7F800000;
                2:       d = 32'h7FC00001;
                3:       d = {1'b0, 8'd0, 23'($urandom)};
                default: d = {($urandom_range(0, 9) == 0), 8'($urandom_range(108, 132)), 23'($urandom)};
            endcase
            drive(v, d);
            n_tests++; if (bus.lut_addr !== exp_addr) begin n_fail++; $display("FAIL random_addr[%0d]: got %0d expected %0d", i, bus.lut_addr, exp_addr); end
            n_tests++; if (bus.lut_rden !== exp_rden) begin n_fail++; $display("FAIL random_rden[%0d]: got %b expected %b", i, bus.lut_rden, exp_rden); end
            n_tests++; if (bus.out_valid !== exp_ovalid) begin n_fail++; $display("FAIL random_out_valid[%0d]: got %b expected %b", i, bus.out_valid, exp_ovalid); end
            if (exp_ovalid) begin
                n_tests++; if (bus.out_in_range !== exp_inr || bus.out_near !== exp_near) begin n_fail++; $display("FAIL random_flags[%0d]: got in_range=%b near=%b expected %b %b", i, bus.out_in_range, bus.out_near, exp_inr, exp_near); end
                n_tests++; if (bus.out_frac !== exp_frac || bus.out_r2 !== exp_r2) begin n_fail++; $display("FAIL random_data[%0d]: got frac=%0h r2=%0h expected %0h %0h", i, bus.out_frac, bus.out_r2, exp_frac, exp_r2); end
            end
        end
        drive(1'b0, 32'd0);
        drive(1'b0, 32'd0);
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 32'h3F000000);
        drive(1'b1, 32'h3E800000);
        drive(1'b1, 32'h3BFFFFFF);
        bus.r2_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_tests++; if (bus.lut_addr !== 12'd0 || bus.lut_rden !== 1'b0) begin n_fail++; $display("FAIL midreset_addr: got addr=%0d rden=%b expected 0 0", bus.lut_addr, bus.lut_rden); end
        n_tests++; if (bus.out_valid !== 1'b0 || bus.out_in_range !== 1'b0 || bus.out_near !== 1'b0) begin n_fail++; $display("FAIL midreset_flags: got valid=%b in_range=%b near=%b expected 0 0 0", bus.out_valid, bus.out_in_range, bus.out_near); end
        n_tests++; if (bus.out_frac !== 15'd0 || bus.out_r2 !== 32'd0) begin n_fail++; $display("FAIL midreset_data: got frac=%0h r2=%0h expected 0 0", bus.out_frac, bus.out_r2); end
        @(posedge clock);
        #1;
        rst = 1'b0;
        clear_model();
        drive(1'b0, 32'd0);
        n_tests++; if (bus.out_valid !== 1'b0 || bus.lut_addr !== 12'd0) begin n_fail++; $display("FAIL midreset_flush: got valid=%b addr=%0d expected 0 0", bus.out_valid, bus.lut_addr); end
        drive(1'b1, 32'h3F000000);
        n_tests++; if (bus.lut_addr !== 12'd2816 || bus.lut_rden !== 1'b1) begin n_fail++; $display("FAIL midreset_first_addr: got addr=%0d rden=%b expected 2816 1", bus.lut_addr, bus.lut_rden); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_lat1: got out_valid=%b expected 0", bus.out_valid); end
        drive(1'b0, 32'd0);
        n_tests++; if (bus.out_valid !== 1'b0 || bus.lut_rden !== 1'b0) begin n_fail++; $display("FAIL midreset_lat2: got valid=%b rden=%b expected 0 0", bus.out_valid, bus.lut_rden); end
        drive(1'b0, 32'd0);
        n_tests++; if (bus.out_valid !== 1'b1 || bus.out_r2 !== 32'h3F000000) begin n_fail++; $display("FAIL midreset_lat3: got valid=%b r2=%0h expected 1 3f000000", bus.out_valid, bus.out_r2); end
        drive(1'b0, 32'd0);
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_single: got out_valid=%b expected 0", bus.out_valid); end
    endtask

`ifdef R2_OOR_COUNT_EN
    task automatic test_counters();
        int n_near = 0;
        int n_far  = 0;
        rst = 1'b1;
        #1;
        @(posedge clock);
        #1;
        rst = 1'b0;
        clear_model();
        n_tests++; if (oor_near_cnt !== 16'd0 || oor_far_cnt !== 16'd0) begin n_fail++; $display("FAIL cnt_reset: got %0d %0d expected 0 0", oor_near_cnt, oor_far_cnt); end
        for (int i = 0; i < 12; i++) begin
            if (i % 3 == 0 && n_near < 5) begin
                drive(1'b1, {1'b0, 8'($urandom_range(0, 114)), 23'($urandom)}); n_near++;
            end else if (i % 3 == 1 && n_far < 3) begin
                drive(1'b1, {1'b0, 8'($urandom_range(127, 255)), 23'($urandom)}); n_far++;
            end else if (n_near < 5) begin
                drive(1'b1, 32'd0); n_near++;
            end else begin
                drive(1'b1, 32'h3F123456);
            end
            drive(1'b0, 32'h7F800000);
        end
        n_tests++; if (oor_near_cnt !== 16'd5 || oor_far_cnt !== 16'd3) begin n_fail++; $display("FAIL cnt_small: got near=%0d far=%0d expected 5 3", oor_near_cnt, oor_far_cnt); end
        n_tests++; if (oor_near_cnt !== 16'(exp_near_cnt) || oor_far_cnt !== 16'(exp_far_cnt)) begin n_fail++; $display("FAIL cnt_model: got near=%0d far=%0d expected %0d %0d", oor_near_cnt, oor_far_cnt, exp_near_cnt, exp_far_cnt); end
        for (int i = 0; i < 70000; i++) begin
            drive(1'b1, 32'h3F800000);
        end
        n_tests++; if (oor_far_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_saturate: got %0h expected ffff", oor_far_cnt); end
        n_tests++; if (oor_near_cnt !== 16'd5) begin n_fail++; $display("FAIL cnt_near_hold: got %0d expected 5", oor_near_cnt); end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_midstream();
`ifdef R2_OOR_COUNT_EN
        test_counters();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
